// File: rtl/hamming_secded_corrector.sv
// hamming_secded_corrector: single registered stage that corrects (8,4) SECDED codewords
// with valid/ready on both sides. Optional saturating error counters: HAMMING_ERR_COUNTERS_EN.
module hamming_secded_corrector #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_cw,
    input  logic [2:0]       in_syn,
    input  logic             in_ov,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [7:0]       out_cw,
    output logic             err_single,
    output logic             err_double,
    output logic [2:0]       err_pos,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    logic       w_accept;
    logic       w_single;
    logic       w_double;
    logic [7:0] w_flip;
    logic [7:0] w_cw_fix;

    logic       r_valid;
    logic [7:0] r_cw;
    logic       r_single;
    logic       r_double;
    logic [2:0] r_pos;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Odd overall parity means exactly one flip; syn then names it (0 selects p0 itself).
    assign w_single = in_ov;
    assign w_double = !in_ov && (in_syn != 3'd0);
    assign w_flip   = 8'd1 << in_syn;
    assign w_cw_fix = w_single ? (in_cw ^ w_flip) : in_cw;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_cw     <= 8'd0;
            r_single <= 1'b0;
            r_double <= 1'b0;
            r_pos    <= 3'd0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_cw     <= w_cw_fix;
            r_single <= w_single;
            r_double <= w_double;
            r_pos    <= w_single ? in_syn : 3'd0;
        end else if (out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign out_valid  = r_valid;
    assign out_cw     = r_cw;
    assign out_data   = {r_cw[7], r_cw[6], r_cw[5], r_cw[3]};
    assign err_single = r_single;
    assign err_double = r_double;
    assign err_pos    = r_pos;

`ifdef HAMMING_ERR_COUNTERS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_uncorr_cnt;

    // Clear wins over a same-cycle increment; counts stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_accept) begin
            if (w_single && (r_corr_cnt != CNT_MAX)) begin
                r_corr_cnt <= r_corr_cnt + 1'b1;
            end
            if (w_double && (r_uncorr_cnt != CNT_MAX)) begin
                r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
            end
        end
    end

    assign corr_cnt   = r_corr_cnt;
    assign uncorr_cnt = r_uncorr_cnt;
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = cnt_clr;
    assign corr_cnt         = '0;
    assign uncorr_cnt       = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_corrector.sv
// Scoreboard bench for hamming_secded_corrector: words are built by a Hamming encoder plus
// error injection, and checked by a monitor decoupled from stimulus.
module tb_hamming_secded_corrector;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_cw = 8'd0;
    logic [2:0]       in_syn = 3'd0;
    logic             in_ov = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [3:0]       out_data;
    logic [7:0]       out_cw;
    logic             err_single;
    logic             err_double;
    logic [2:0]       err_pos;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    hamming_secded_corrector #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cw(in_cw), .in_syn(in_syn), .in_ov(in_ov),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_cw(out_cw),
        .err_single(err_single), .err_double(err_double), .err_pos(err_pos),
        .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cw;
        logic [3:0] data;
        logic       single;
        logic       double;
        logic [2:0] pos;
    } exp_t;

    exp_t sb[$];
    exp_t cur_exp;
    exp_t mon_e;
    int   n_pass = 0;
    int   n_total = 0;
    int   m_corr = 0;
    int   m_uncorr = 0;
    int   ready_mode = 0;
    bit   last_acc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Textbook (8,4) encoder: data at 3,5,6,7; p1/p2/p3 cover positions with that bit set.
    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] c;
        c    = 8'd0;
        c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3];
        c[1] = c[3] ^ c[5] ^ c[7];
        c[2] = c[3] ^ c[6] ^ c[7];
        c[4] = c[5] ^ c[6] ^ c[7];
        c[0] = ^c[7:1];
        return c;
    endfunction

    function automatic logic [2:0] syndrome(input logic [7:0] c);
        logic [2:0] s;
        s = 3'd0;
        for (int k = 1; k < 8; k++) if (c[k]) s ^= 3'(k);
        return s;
    endfunction

    // Inputs are driven #1 after posedge; returns #1 after the posedge that accepted the word.
    task automatic send(input logic [3:0] d, input int nerr, input int e1, input int e2);
        logic [7:0] clean, raw;
        exp_t e;
        bit done;
        clean = encode(d);
        raw = clean;
        if (nerr >= 1) raw[e1] = ~raw[e1];
        if (nerr == 2) raw[e2] = ~raw[e2];
        e.cw     = (nerr == 2) ? raw : clean;
        e.data   = (nerr == 2) ? {raw[7], raw[6], raw[5], raw[3]} : d;
        e.single = (nerr == 1);
        e.double = (nerr == 2);
        e.pos    = (nerr == 1) ? 3'(e1) : 3'd0;
        cur_exp  = e;
        in_cw    = raw;
        in_syn   = syndrome(raw);
        in_ov    = ^raw;
        in_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            #2;
            if (last_acc) done = 1'b1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_cw    = 8'($urandom);
        in_syn   = 3'($urandom);
        in_ov    = 1'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input int mode);
        ready_mode = mode;
        if (mode == 0) out_ready = 1'b1;
        if (mode == 2) out_ready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, out_valid, 32'd0);
        check({tag, "_in_ready"}, in_ready, 32'd1);
        check({tag, "_out_cw"}, out_cw, 32'd0);
        check({tag, "_out_data"}, out_data, 32'd0);
        check({tag, "_flags"}, {err_single, err_double, err_pos}, 32'd0);
        check({tag, "_cnts"}, {corr_cnt, uncorr_cnt}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Accept detection: records what the next posedge will capture.
    always @(negedge clk) begin
        #1;
        last_acc = 1'b0;
        if (rst) begin
            sb.delete();
            m_corr = 0;
            m_uncorr = 0;
        end else begin
            if (in_valid && in_ready) begin
                sb.push_back(cur_exp);
                last_acc = 1'b1;
            end
`ifdef HAMMING_ERR_COUNTERS_EN
            if (cnt_clr) begin
                m_corr = 0;
                m_uncorr = 0;
            end else if (last_acc) begin
                if (cur_exp.single && m_corr < CNT_MAX) m_corr++;
                if (cur_exp.double && m_uncorr < CNT_MAX) m_uncorr++;
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", in_ready, (sb.size() == 0 || out_ready));
            check("out_valid", out_valid, (sb.size() != 0));
            check("corr_cnt", corr_cnt, m_corr);
            check("uncorr_cnt", uncorr_cnt, m_uncorr);
            if (out_valid && out_ready && sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("out_cw", out_cw, mon_e.cw);
                check("out_data", out_data, mon_e.data);
                check("err_single", err_single, mon_e.single);
                check("err_double", err_double, mon_e.double);
                check("err_pos", err_pos, mon_e.pos);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int nerr, e1, e2;
        idle(3);
        rst = 1'b0;
        check_idle_outputs("reset");

        // Directed words: AA clean, bit-5 flip, p0 flip, bits 6+5 flipped (syn=3, ov=0).
        send(4'hB, 0, 0, 0);
        send(4'hB, 1, 5, 0);
        send(4'hB, 1, 0, 0);
        send(4'hB, 2, 6, 5);
        idle(2);

        // Backpressure: first word accepted, second stalls for 3 clocks.
        set_ready(2);
        send(4'h3, 1, 7, 0);
        fork
            send(4'hC, 2, 1, 4);
            begin
                idle(3);
                set_ready(0);
            end
        join
        idle(3);

        // Reset while a word is pending on a stalled sink.
        set_ready(2);
        send(4'h6, 1, 2, 0);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_idle_outputs("midrst");
        set_ready(0);

        // Counter saturation, then clear coinciding with a single-error accept.
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) send(4'($urandom), 1, $urandom_range(0, 7), 0);
        idle(2);
        @(negedge clk);
`ifdef HAMMING_ERR_COUNTERS_EN
        check("corr_saturated", corr_cnt, 32'd3);
`else
        check("corr_tied_zero", corr_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        cnt_clr = 1'b1;
        send(4'h9, 1, 3, 0);
        cnt_clr = 1'b0;
        @(negedge clk);
        check("corr_cleared", corr_cnt, 32'd0);
        @(posedge clk);
        #1;

        // Random traffic with random sink stalls and occasional counter clears.
        for (int i = 0; i < 300; i++) begin
            set_ready(i < 200 ? 1 : 0);
            nerr = $urandom_range(0, 2);
            e1 = $urandom_range(0, 7);
            e2 = (e1 + $urandom_range(1, 7)) % 8;
            cnt_clr = ($urandom_range(0, 15) == 0);
            send(4'($urandom), nerr, e1, e2);
            cnt_clr = 1'b0;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        set_ready(0);
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        check("drain", sb.size(), 32'd0);
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
